// File: rtl/hippo_alu_pkg.sv
// rtl/hippo_alu_pkg.sv - shared types and constants for the hippo_alu integer ALU
package hippo_alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_EXOR = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } ALUOp;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/hippo_alu_shifter.sv
// rtl/hippo_alu_shifter.sv - barrel shifter covering SLL, SRL and SRA
module hippo_alu_shifter
  import hippo_alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [4:0]      shamt,
  input  shift_dir_e      dir,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sra_val;
  logic [XLEN-1:0] srl_val;
  logic [XLEN-1:0] sll_val;

  assign sra_val = XLEN'($signed(a) >>> shamt);
  assign srl_val = a >> shamt;
  assign sll_val = a << shamt;

  always_comb begin
    result = sll_val;
    if (dir == SHIFT_RIGHT) begin
      result = arith ? sra_val : srl_val;
    end
  end

endmodule

// File: rtl/hippo_alu.sv
// rtl/hippo_alu.sv - RV32I execute-stage ALU with combinational and registered result
module hippo_alu
  import hippo_alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  input  logic            sub_arith,
  input  logic            en,
  output logic [XLEN-1:0] res,
  output logic [XLEN-1:0] res_q
);

  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] shift_res;
  logic            lt_signed;
  logic            lt_unsigned;
  shift_dir_e      shift_dir;

  assign add_res     = sub_arith ? (a - b) : (a + b);
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;
  assign shift_dir   = (op == ALU_SR) ? SHIFT_RIGHT : SHIFT_LEFT;

  // Only SRA cares about sub_arith; SLL ignores the arith flag inside the shifter.
  hippo_alu_shifter u_shifter (
    .a      (a),
    .shamt  (b[4:0]),
    .dir    (shift_dir),
    .arith  (sub_arith),
    .result (shift_res)
  );

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = add_res;
      ALU_SLL:  res = shift_res;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_EXOR: res = a ^ b;
      ALU_SR:   res = shift_res;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
    end else if (en) begin
      res_q <= res;
    end
  end

endmodule

// File: tb/tb_hippo_alu.sv
// tb/tb_hippo_alu.sv - self-checking bench for hippo_alu
module tb_hippo_alu;
  import hippo_alu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        sub_arith;
  logic        en;
  logic [31:0] res;
  logic [31:0] res_q;

  int checks;
  int failures;
  logic [31:0] q_model;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sub;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  hippo_alu dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .op        (op),
    .sub_arith (sub_arith),
    .en        (en),
    .res       (res),
    .res_q     (res_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model in plain arithmetic terms: shifts as multiply/divide by powers of two.
  function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [2:0] mop, input logic msub);
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint unsigned pow;
    longint unsigned q;
    ua  = {32'd0, ma};
    ub  = {32'd0, mb};
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    pow = 64'd1 << mb[4:0];
    case (mop)
      3'd0: return msub ? 32'(ua - ub) : 32'(ua + ub);
      3'd1: return 32'(ua * pow);
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (ua < ub) ? 32'd1 : 32'd0;
      3'd4: return ma ^ mb;
      3'd5: begin
        if (msub && sa < 0) begin
          // floor division of a negative number
          q = 64'((sa - longint'(pow) + 1) / longint'(pow));
        end else begin
          q = ua / pow;
        end
        return 32'(q);
      end
      3'd6: return ma | mb;
      default: return ma & mb;
    endcase
  endfunction

  task automatic apply(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top,
                       input logic tsub, input logic ten, input logic [31:0] texp,
                       input string name);
    @(negedge clk);
    a = ta; b = tb_; op = top; sub_arith = tsub; en = ten;
    #1;
    check(name, res, texp);
    if (ten) q_model = texp;
    @(posedge clk);
    #1;
    check({name, "_q"}, res_q, q_model);
  endtask

  initial begin
    checks = 0; failures = 0; q_model = 32'd0;
    reset = 1'b1; a = 32'd0; b = 32'd0; op = 3'd0; sub_arith = 1'b0; en = 1'b0;

    vecs.push_back('{"add",      32'd3,  32'd5, ALU_ADD,  1'b0, 32'd8});
    vecs.push_back('{"sub",      32'd3,  32'd5, ALU_ADD,  1'b1, 32'hFFFF_FFFE});
    vecs.push_back('{"slt_3_5",  32'd3,  32'd5, ALU_SLT,  1'b0, 32'd1});
    vecs.push_back('{"sltu_3_5", 32'd3,  32'd5, ALU_SLTU, 1'b0, 32'd1});
    vecs.push_back('{"slt_m3_5", -32'sd3, 32'd5, ALU_SLT,  1'b0, 32'd1});
    vecs.push_back('{"sltu_m3_5",-32'sd3, 32'd5, ALU_SLTU, 1'b0, 32'd0});
    vecs.push_back('{"slt_m3_m5",-32'sd3, -32'sd5, ALU_SLT, 1'b0, 32'd0});
    vecs.push_back('{"sltu_m3_m5",-32'sd3,-32'sd5, ALU_SLTU,1'b0, 32'd0});
    vecs.push_back('{"slt_3_m5", 32'd3, -32'sd5, ALU_SLT,  1'b1, 32'd0});
    vecs.push_back('{"sltu_3_m5",32'd3, -32'sd5, ALU_SLTU, 1'b1, 32'd1});
    vecs.push_back('{"sll",      32'd3,  32'd2, ALU_SLL,  1'b1, 32'd12});
    vecs.push_back('{"srl_12",   32'd12, 32'd2, ALU_SR,   1'b0, 32'd3});
    vecs.push_back('{"sra_12",   32'd12, 32'd2, ALU_SR,   1'b1, 32'd3});
    vecs.push_back('{"srl_m12",  -32'sd12, 32'd2, ALU_SR, 1'b0, 32'h3FFF_FFFD});
    vecs.push_back('{"sra_m12",  -32'sd12, 32'd2, ALU_SR, 1'b1, 32'hFFFF_FFFD});
    vecs.push_back('{"xor",      32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_EXOR, 1'b1, 32'hFF00_0FF0});
    vecs.push_back('{"or",       32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_OR,   1'b1, 32'hFFF0_0FFF});
    vecs.push_back('{"and",      32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_AND,  1'b1, 32'h00F0_000F});
    vecs.push_back('{"sll_0",    32'hDEAD_BEEF, 32'hFFFF_FFE0, ALU_SLL, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{"sra_0",    32'h8000_0001, 32'h0000_0020, ALU_SR,  1'b1, 32'h8000_0001});
    vecs.push_back('{"sll_31",   32'h0000_0003, 32'd31, ALU_SLL, 1'b0, 32'h8000_0000});
    vecs.push_back('{"srl_31",   32'h8000_0000, 32'd31, ALU_SR,  1'b0, 32'h0000_0001});
    vecs.push_back('{"sra_31",   32'h8000_0000, 32'd31, ALU_SR,  1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{"add_wrap", 32'hFFFF_FFFF, 32'd1,  ALU_ADD, 1'b0, 32'd0});

    #2;
    check("reset_q", res_q, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sub, 1'b1, vecs[i].exp, vecs[i].name);
    end

    // hold: en=0 while inputs change
    apply(32'd3, 32'd5, ALU_ADD, 1'b0, 1'b1, 32'd8, "load8");
    apply(32'd100, 32'd1, ALU_ADD, 1'b0, 1'b0, 32'd101, "hold1");
    apply(32'h1234_5678, 32'd4, ALU_SLL, 1'b0, 1'b0, 32'h2345_6780, "hold2");

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_q", res_q, 32'd0);
    q_model = 32'd0;
    @(posedge clk);
    #1;
    check("reset_dominates_en", res_q, 32'd0);
    en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      logic        rsub;
      logic        ren;
      ra   = $urandom;
      rb   = $urandom;
      if (i % 4 == 0) rb = $urandom_range(0, 40);
      if (i % 7 == 0) rb = ra;
      rop  = 3'($urandom_range(0, 7));
      rsub = 1'($urandom_range(0, 1));
      ren  = 1'($urandom_range(0, 1));
      apply(ra, rb, rop, rsub, ren, model(ra, rb, rop, rsub), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
